// File: rtl/pos_bcd_converter.sv
// pos_bcd_converter: sequential double-dabble binary-to-BCD for the cursor x/y cell position
module pos_bcd_converter #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 99
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] x_pos,
    input  logic [Y_W-1:0] y_pos,
    output logic           busy,
    output logic           done,
    output logic [3:0]     x_huns,
    output logic [3:0]     x_tens,
    output logic [3:0]     x_ones,
    output logic [3:0]     y_tens,
    output logic [3:0]     y_ones,
    output logic           x_ovf,
    output logic           y_ovf
);
    localparam int CYC   = (X_W > Y_W) ? X_W : Y_W;
    localparam int CNT_W = $clog2(CYC + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CYC-1:0]   xo_q, xo_d, yo_q, yo_d;
    logic [11:0]      xs_q, xs_d, xa;
    logic [7:0]       ys_q, ys_d, ya;
    logic             pend_q, pend_d;
    logic             xv_q, xv_d, yv_q, yv_d;
    logic [11:0]      xdig_q, xdig_d;
    logic [7:0]       ydig_q, ydig_d;
    logic             xovf_q, xovf_d, yovf_q, yovf_d;
    logic             done_q, done_d;
    logic             commit, launch;

    function automatic logic [11:0] fix3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [7:0] fix2(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < 2; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction

    // next state: shift step, commit of results, and (re)launch from IDLE or a pending request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        xv_d    = xv_q;
        yv_d    = yv_q;
        xdig_d  = xdig_q;
        ydig_d  = ydig_q;
        xovf_d  = xovf_q;
        yovf_d  = yovf_q;
        done_d  = 1'b0;
        xa      = fix3(xs_q);
        ya      = fix2(ys_q);
        commit  = (state_q == SHIFT) && (cnt_q == '0);
        launch  = ((state_q == IDLE) && (start || pend_q)) || (commit && pend_q);
        pend_d  = (state_q == SHIFT) && (commit ? start : (pend_q || start));
        if ((state_q == SHIFT) && (cnt_q != '0)) begin
            {xs_d, xo_d} = {xa, xo_q} << 1;
            {ys_d, yo_d} = {ya, yo_q} << 1;
            cnt_d        = cnt_q - 1'b1;
        end
        if (commit) begin
            xdig_d  = xv_q ? 12'hFFF : xs_q;
            ydig_d  = yv_q ? 8'hFF : ys_q;
            xovf_d  = xv_q;
            yovf_d  = yv_q;
            done_d  = 1'b1;
            state_d = IDLE;
        end
        if (launch) begin
            xo_d    = CYC'(x_pos);
            yo_d    = CYC'(y_pos);
            xs_d    = '0;
            ys_d    = '0;
            xv_d    = x_pos > X_W'(X_MAX);
            yv_d    = y_pos > Y_W'(Y_MAX);
            cnt_d   = CNT_W'(CYC);
            state_d = SHIFT;
        end
    end

    // state registers with synchronous reset; reset aborts any conversion silently
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            xv_q    <= 1'b0;
            yv_q    <= 1'b0;
            pend_q  <= 1'b0;
            xdig_q  <= '0;
            ydig_q  <= '0;
            xovf_q  <= 1'b0;
            yovf_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            xv_q    <= xv_d;
            yv_q    <= yv_d;
            pend_q  <= pend_d;
            xdig_q  <= xdig_d;
            ydig_q  <= ydig_d;
            xovf_q  <= xovf_d;
            yovf_q  <= yovf_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = done_q;
    assign x_huns = xdig_q[11:8];
    assign x_tens = xdig_q[7:4];
    assign x_ones = xdig_q[3:0];
    assign y_tens = ydig_q[7:4];
    assign y_ones = ydig_q[3:0];
    assign x_ovf  = xovf_q;
    assign y_ovf  = yovf_q;
endmodule

// File: tb/tb_pos_bcd_converter.sv
// tb_pos_bcd_converter: scoreboard bench for the cursor position BCD converter
module tb_pos_bcd_converter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x_pos = '0;
    logic [6:0] y_pos = '0;
    logic       busy, done, x_ovf, y_ovf;
    logic [3:0] x_huns, x_tens, x_ones, y_tens, y_ones;

    typedef struct {
        logic [21:0] v;
        int          at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    pos_bcd_converter dut (
        .clk(clk), .reset(reset), .start(start), .x_pos(x_pos), .y_pos(y_pos),
        .busy(busy), .done(done), .x_huns(x_huns), .x_tens(x_tens), .x_ones(x_ones),
        .y_tens(y_tens), .y_ones(y_ones), .x_ovf(x_ovf), .y_ovf(y_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [21:0] model(input int x, input int y);
        logic [11:0] xd;
        logic [7:0]  yd;
        xd = (x > 159) ? 12'hFFF : {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
        yd = (y > 99) ? 8'hFF : {4'(y / 10), 4'(y % 10)};
        return {xd, yd, x > 159, y > 99};
    endfunction

    // scoreboard: every done pulse must match the oldest outstanding expectation, on its cycle
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 32'({x_huns, x_tens, x_ones, y_tens, y_ones, x_ovf, y_ovf}), 32'(e.v));
                check("latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic go(input int x, input int y, input bit push);
        exp_t e;
        x_pos = 8'(x);
        y_pos = 7'(y);
        start = 1'b1;
        e.v   = model(x, y);
        e.at  = cyc + 1 + 9;
        if (push) q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) check("done_timeout", 32'(n), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        idle(3);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out", 32'({x_huns, x_tens, x_ones, y_tens, y_ones, x_ovf, y_ovf}), 32'd0);
        reset = 1'b0;
        idle(1);
        go(123, 45, 1);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done();
        check("busy_in_done", 32'(busy), 32'd0);
        idle(2);
        go(0, 0, 1);
        wait_done();
        check("b2b_idle_in_done", 32'(busy), 32'd0);
        go(159, 99, 1);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done();
        idle(1);
        go(200, 100, 1);
        wait_done();
        idle(1);
        go(7, 3, 1);
        wait_done();
        idle(2);
        go(10, 20, 1);
        e.at = cyc + 18;
        idle(2);
        x_pos = 8'd11;
        y_pos = 7'd21;
        start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(1);
        x_pos = 8'd12;
        y_pos = 7'd22;
        start = 1'b1;
        e.v = model(12, 22);
        q.push_back(e);
        idle(1);
        start = 1'b0;
        wait_done();
        check("pending_busy_in_done", 32'(busy), 32'd1);
        wait_done();
        check("pending_idle_after", 32'(busy), 32'd0);
        idle(15);
        check("pending_single_extra", 32'(busy), 32'd0);
        go(88, 77, 0);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_digits", 32'({x_huns, x_tens, x_ones, y_tens, y_ones, x_ovf, y_ovf}), 32'd0);
        idle(12);
        check("abort_no_done", 32'(done), 32'd0);
        go(42, 9, 1);
        wait_done();
        idle(2);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
